// File: rtl/histogram_seq_ctrl.sv
// Sequencing controller for the histogram kernel: clears the bin RAM, then streams
// pixels through a 3-stage read-modify-write pipeline with same-bin forwarding.
module histogram_seq_ctrl #(
  parameter int IMG_ADDR_W = 12,
  parameter int BIN_ADDR_W = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IMG_ADDR_W:0]   num_pixels,
  output logic                  busy,
  output logic                  valid,
  output logic [IMG_ADDR_W-1:0] arg_0_raddr_0,
  input  logic [BIN_ADDR_W-1:0] arg_0_rdata_0,
  output logic [BIN_ADDR_W-1:0] arg_1_raddr_0,
  input  logic [CNT_W-1:0]      arg_1_rdata_0,
  output logic [BIN_ADDR_W-1:0] arg_1_waddr_0,
  output logic [CNT_W-1:0]      arg_1_wdata_0,
  output logic                  arg_1_wen_0,
  input  logic [BIN_ADDR_W-1:0] host_raddr,
  output logic [CNT_W-1:0]      host_rdata
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  localparam logic [IMG_ADDR_W:0] MAX_PIX = {1'b1, {IMG_ADDR_W{1'b0}}};

  state_t                state_reg;
  logic [IMG_ADDR_W:0]   n_reg;
  logic [IMG_ADDR_W:0]   pix_cnt_reg;
  logic [BIN_ADDR_W-1:0] clr_cnt_reg;
  logic                  drain_cnt_reg;
  logic                  s1_vld_reg;
  logic                  s2_vld_reg;
  logic [BIN_ADDR_W-1:0] b2_reg;
  logic                  fwd_vld_reg;
  logic [BIN_ADDR_W-1:0] fwd_bin_reg;
  logic [CNT_W-1:0]      fwd_data_reg;
  logic                  busy_reg;
  logic                  valid_reg;

  logic [IMG_ADDR_W:0]   n_sat;
  logic [CNT_W-1:0]      operand;
  logic [CNT_W-1:0]      s2_wdata;

  assign n_sat    = (num_pixels > MAX_PIX) ? MAX_PIX : num_pixels;
  // Distance-1 hazard: the previous pixel's write is not yet visible in the RAM read.
  assign operand  = (fwd_vld_reg && (fwd_bin_reg == b2_reg)) ? fwd_data_reg : arg_1_rdata_0;
  assign s2_wdata = operand + CNT_W'(1);

  assign busy       = busy_reg;
  assign valid      = valid_reg;
  assign host_rdata = arg_1_rdata_0;

  always_comb begin
    arg_0_raddr_0 = '0;
    arg_1_raddr_0 = '0;
    arg_1_waddr_0 = '0;
    arg_1_wdata_0 = '0;
    arg_1_wen_0   = 1'b0;
    if (state_reg == RUN)
      arg_0_raddr_0 = pix_cnt_reg[IMG_ADDR_W-1:0];
    if (s1_vld_reg)
      arg_1_raddr_0 = arg_0_rdata_0;
    else if (state_reg == DONE)
      arg_1_raddr_0 = host_raddr;
    if (state_reg == CLEAR) begin
      arg_1_waddr_0 = clr_cnt_reg;
      arg_1_wen_0   = 1'b1;
    end else if (s2_vld_reg) begin
      arg_1_waddr_0 = b2_reg;
      arg_1_wdata_0 = s2_wdata;
      arg_1_wen_0   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      pix_cnt_reg   <= '0;
      clr_cnt_reg   <= '0;
      drain_cnt_reg <= 1'b0;
      s1_vld_reg    <= 1'b0;
      s2_vld_reg    <= 1'b0;
      b2_reg        <= '0;
      fwd_vld_reg   <= 1'b0;
      fwd_bin_reg   <= '0;
      fwd_data_reg  <= '0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      s1_vld_reg   <= (state_reg == RUN);
      s2_vld_reg   <= s1_vld_reg;
      b2_reg       <= arg_0_rdata_0;
      fwd_vld_reg  <= s2_vld_reg;
      fwd_bin_reg  <= b2_reg;
      fwd_data_reg <= s2_wdata;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg   <= CLEAR;
            n_reg       <= n_sat;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            valid_reg   <= 1'b0;
          end
        end
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == {BIN_ADDR_W{1'b1}}) begin
            pix_cnt_reg <= '0;
            if (n_reg == '0) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              valid_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          pix_cnt_reg <= pix_cnt_reg + 1'b1;
          if (pix_cnt_reg == n_reg - 1'b1) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt_reg <= 1'b1;
          if (drain_cnt_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/histogram_seq_ctrl.md
# histogram_seq_ctrl

Sequencing controller for the pipelined histogram kernel datapath. It owns the 256-entry × 32-bit bin RAM (arg_1) and the 4096-entry × 8-bit image RAM (arg_0) read port. On each start it clears all bins, then streams `num_pixels` pixels at one pixel per cycle through a read-modify-write pipeline with same-bin forwarding. When the run completes it holds `valid` and gives a host read port onto the bins.

## Interface
Parameters:
- IMG_ADDR_W, 12: image RAM address width; max image size is 2^IMG_ADDR_W pixels.
- BIN_ADDR_W, 8: bin RAM address width; bin count is 2^BIN_ADDR_W; pixel width equals BIN_ADDR_W.
- CNT_W, 32: bin counter width.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- start, in, 1: starts a run; sampled only in IDLE or DONE.
- num_pixels, in, IMG_ADDR_W+1: pixel count (0..4096), captured when start is accepted.
- busy, out, 1: high in CLEAR, RUN and DRAIN.
- valid, out, 1: high in DONE.
- arg_0_raddr_0, out, IMG_ADDR_W: image read address.
- arg_0_rdata_0, in, BIN_ADDR_W: image read data, one cycle after the address.
- arg_1_raddr_0, out, BIN_ADDR_W: bin read address.
- arg_1_rdata_0, in, CNT_W: bin read data, one cycle after the address.
- arg_1_waddr_0, out, BIN_ADDR_W: bin write address.
- arg_1_wdata_0, out, CNT_W: bin write data.
- arg_1_wen_0, out, 1: bin write enable; the write commits at the clock edge.
- host_raddr, in, BIN_ADDR_W: bin readout address, honoured in DONE only.
- host_rdata, out, CNT_W: equals arg_1_rdata_0.

## Operation
Memory model:
- Both RAMs have synchronous read with 1-cycle latency.
- The bin RAM is read-before-write: a read and a write to the same address in the same cycle returns the old value.

States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: start=1 → CLEAR; num_pixels is latched into N.
- CLEAR: clr_cnt runs 0..255; each cycle writes waddr=clr_cnt, wdata=0, wen=1. After clr_cnt=255 → RUN, or → DONE if N=0.
- RUN: pix_cnt runs 0..N-1; stage S0 issues arg_0_raddr_0=pix_cnt. After pix_cnt=N-1 → DRAIN.
- DRAIN: exactly 2 cycles so the in-flight S1 and S2 stages complete, then → DONE.
- DONE: arg_1_raddr_0=host_raddr. start=1 → CLEAR (new run; N relatched). start is ignored in every other state.

Pipeline, one pixel per cycle, each stage with its own valid bit:
- S0: issue the image read.
- S1: bin b1=arg_0_rdata_0; drive arg_1_raddr_0=b1.
- S2: b2 is the registered b1. Operand = fwd_data if (fwd_vld && fwd_bin==b2), else arg_1_rdata_0. Write waddr=b2, wdata=operand+1 (mod 2^CNT_W), wen=1.
- Forward register: updated every cycle with fwd_vld=S2 valid, fwd_bin=b2, fwd_data=wdata. It covers a distance-1 same-bin hazard. At distance ≥2 the earlier write has already committed before the later read, so no forwarding is needed.

Port defaults:
- arg_1_wen_0=0 whenever neither CLEAR nor S2 is writing.
- Address outputs hold 0 when not driven.
- CLEAR writes and S2 writes never overlap, because RUN starts only after CLEAR ends.

## Timing
Reset:
- rst forces IDLE on the next edge.
- All pipeline valids, fwd_vld, counters and N go to 0.
- busy=0, valid=0, arg_1_wen_0=0; all addresses and wdata are 0.
- Reset mid-operation abandons the run. No write is issued in the cycle after rst is sampled.

Latency, with start high in cycle 0:
- CLEAR occupies cycles 1–256.
- RUN occupies cycles 257..256+N.
- DRAIN occupies cycles 257+N and 258+N.
- valid=1 from cycle 259+N. For N=0, valid=1 from cycle 257.

Other timing:
- Pixel k reads the image at cycle 257+k, reads its bin at 258+k and writes its bin at 259+k.
- Host readout: host_raddr applied in cycle t gives host_rdata in cycle t+1.
- num_pixels above 2^IMG_ADDR_W is saturated to 2^IMG_ADDR_W.

## Test plan
- Reset: assert rst for 3 cycles with start=1 → busy=0, valid=0, wen=0 throughout, state stays IDLE.
- Distinct pixels: image [1,2,3,4], N=4 → valid at cycle 263; bins 1–4 = 1; all other bins = 0 via host readout.
- Back-to-back same bin: 8 pixels all equal to 7 → bin7 = 8 (exercises forwarding every cycle); bin6 = 0.
- Distance-2 hazard: image [5,9,5,9,5] → bin5 = 3, bin9 = 2; also [5,5,9,5] → bin5 = 3, bin9 = 1.
- Rerun with clear: run 1 with N=4096 of pixel 0 → bin0 = 4096. Then start with N=0 → valid at cycle 257; bin0 = 0.
- Reset mid-RUN: assert rst at pixel 100 of N=200 with all pixels = 3. Then start with N=10 → bin3 = 10; the start cycle is accepted from IDLE.
